// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
// Geometry comes from the CACHE_T (tag bits) and CACHE_B (byte-offset bits)
// macros, which default to a 26-bit tag and 16-byte lines.
//   state_t      : controller FSM states
//   addr_tag     : tag field of a byte address
//   addr_index   : line index field of a byte address
//   addr_word    : word offset within the line
//   word_addr    : rebuilds a word-aligned byte address from its fields
`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

package cache_pkg;
    localparam int TAG_WIDTH    = `CACHE_T;
    localparam int OFFSET_WIDTH = `CACHE_B;
    localparam int INDEX_WIDTH  = 32 - TAG_WIDTH - OFFSET_WIDTH;
    localparam int WORD_WIDTH   = OFFSET_WIDTH - 2;
    localparam int LINE_SIZE    = 2 ** WORD_WIDTH;

    typedef logic [TAG_WIDTH-1:0]   tag_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [WORD_WIDTH-1:0]  word_off_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } state_t;

    function automatic tag_t addr_tag(input logic [31:0] addr);
        return addr[31:32-TAG_WIDTH];
    endfunction

    function automatic index_t addr_index(input logic [31:0] addr);
        return addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
    endfunction

    function automatic word_off_t addr_word(input logic [31:0] addr);
        return addr[OFFSET_WIDTH-1:2];
    endfunction

    function automatic logic [31:0] word_addr(input tag_t tag, input index_t index,
                                              input word_off_t word);
        return {tag, index, word, 2'b00};
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// Bus interfaces around the cache controller.
//   cpu_bus_if  : CPU memory stage <-> controller. master = CPU, slave = controller.
//                 req/we/addr/wdata in; ready (one-cycle pulse) and rdata out.
//   line_bus_if : controller -> selected line of the external line array.
//                 master = controller, slave = line array.
//   mem_bus_if  : controller -> memory bus. master = controller, slave = memory.
//
// Handshake rule for the memory bus: a word transfers on every rising edge
// where req and ready are both high. The master keeps req, we, addr and wdata
// stable until that edge; ready is meaningless while req is low and may
// already be high in the first cycle req is raised. On the CPU side the
// requester raises req in a single cycle while the controller is idle and then
// waits for the ready pulse; req seen while busy is ignored.

interface cpu_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

interface line_bus_if;
    cache_pkg::index_t    index;
    logic                 we;
    logic                 set_valid;
    logic                 set_dirty;
    cache_pkg::tag_t      tag;
    cache_pkg::word_off_t offset;
    logic [31:0]          wdata;
    logic                 valid;
    logic                 dirty;
    cache_pkg::tag_t      stored_tag;
    logic                 hit;
    logic [31:0]          rdata;

    modport master (output index, we, set_valid, set_dirty, tag, offset, wdata,
                    input valid, dirty, stored_tag, hit, rdata);
    modport slave  (input index, we, set_valid, set_dirty, tag, offset, wdata,
                    output valid, dirty, stored_tag, hit, rdata);
endinterface

interface mem_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, single-port cache controller. Takes one CPU access at a
// time, resolves hits from the line selected by the latched index, and on a
// miss writes back a dirty victim word by word and then refills the line
// before completing the access as a hit.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   cpu          : CPU request / completion (slave side)
//   line         : line array select, write and status (master side)
//   mem          : word-wide memory bus (master side)
//   dbg_state    : current FSM state
module cache_ctrl
    import cache_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    cpu_bus_if.slave    cpu,
    line_bus_if.master  line,
    mem_bus_if.master   mem,
    output state_t      dbg_state
);

    state_t      state;
    word_off_t   count;
    logic        req_we;
    tag_t        req_tag;
    index_t      req_index;
    word_off_t   req_word;
    logic [31:0] req_wdata;

    logic last_word;
    assign last_word = (count == word_off_t'(LINE_SIZE - 1));

    // ---------------- state and latched request ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            count     <= '0;
            req_we    <= 1'b0;
            req_tag   <= '0;
            req_index <= '0;
            req_word  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu.req) begin
                        req_we    <= cpu.we;
                        req_tag   <= addr_tag(cpu.addr);
                        req_index <= addr_index(cpu.addr);
                        req_word  <= addr_word(cpu.addr);
                        req_wdata <= cpu.wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (line.hit) begin
                        state <= IDLE;
                    end else begin
                        count <= '0;
                        state <= (line.valid && line.dirty) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem.ready) begin
                        count <= count + 1'b1;  // wraps to 0 after the last word
                        if (last_word) state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem.ready) begin
                        count <= count + 1'b1;
                        // The line now holds the requested tag, so LOOKUP hits.
                        if (last_word) state <= LOOKUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- output decode ----------------
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        line_we;
    logic        set_valid;
    logic        set_dirty;
    tag_t        line_tag;
    word_off_t   line_offset;
    logic [31:0] line_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    always_comb begin
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        line_we     = 1'b0;
        set_valid   = 1'b0;
        set_dirty   = 1'b0;
        line_tag    = req_tag;
        line_offset = req_word;
        line_wdata  = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            LOOKUP: begin
                if (line.hit) begin
                    cpu_ready = 1'b1;
                    if (req_we) begin
                        line_we    = 1'b1;
                        set_valid  = 1'b1;
                        set_dirty  = 1'b1;
                        line_wdata = req_wdata;
                    end else begin
                        cpu_rdata = line.rdata;
                    end
                end
            end
            WRITEBACK: begin
                // Compare against the stored tag so the victim line hits and
                // returns its words.
                line_tag    = line.stored_tag;
                line_offset = count;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = word_addr(line.stored_tag, req_index, count);
                mem_wdata   = line.rdata;
            end
            REFILL: begin
                line_offset = count;
                mem_req     = 1'b1;
                mem_addr    = word_addr(req_tag, req_index, count);
                if (mem.ready) begin
                    line_we    = 1'b1;
                    set_valid  = 1'b1;
                    line_wdata = mem.rdata;
                end
            end
            default: ;
        endcase
        // A reset abandons whatever is in flight: no completion, no line write.
        if (rst_i) begin
            cpu_ready = 1'b0;
            line_we   = 1'b0;
        end
    end

    assign cpu.ready      = cpu_ready;
    assign cpu.rdata      = cpu_rdata;
    assign line.index     = req_index;
    assign line.we        = line_we;
    assign line.set_valid = set_valid;
    assign line.set_dirty = set_dirty;
    assign line.tag       = line_tag;
    assign line.offset    = line_offset;
    assign line.wdata     = line_wdata;
    assign mem.req        = mem_req;
    assign mem.we         = mem_we;
    assign mem.addr       = mem_addr;
    assign mem.wdata      = mem_wdata;
    assign dbg_state      = state;

endmodule
